// File: rtl/rc5_key_expander.sv
// RC5 key-schedule engine: loads key bytes, then expands them into the S table
// through the LOAD_L, INIT_S and MIX phases. It has a start/busy/done handshake
// and a registered S read port.
module rc5_key_expander #(
    parameter int W = 16,
    parameter int B = 16,
    parameter int R = 12,
    parameter logic [W-1:0] PW = 16'hb7e1,
    parameter logic [W-1:0] QW = 16'h9e37,
    localparam int U  = W / 8,
    localparam int C  = ((B + U - 1) / U < 1) ? 1 : (B + U - 1) / U,
    localparam int T  = 2 * (R + 1),
    localparam int N  = 3 * ((T > C) ? T : C),
    localparam int KA = (B > 1) ? $clog2(B) : 1,
    localparam int SA = $clog2(T)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    iKey_sub_i,
    input  logic [KA-1:0] iKey_address,
    input  logic          iWen,
    input  logic          iStart,
    input  logic [SA-1:0] iS_address,
    output logic [W-1:0]  oS,
    output logic          oBusy,
    output logic          oDone
);

    localparam int LA = (C > 1) ? $clog2(C) : 1;
    localparam int RW = $clog2(W);
    localparam int NW = $clog2(N + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_L,
        INIT_S,
        MIX,
        DONE
    } StateT;

    StateT state;
    StateT nextState;

    logic [7:0]    keyMem [B];
    logic [W-1:0]  lMem   [C];
    logic [W-1:0]  sTable [T];
    logic [W-1:0]  accA;
    logic [W-1:0]  accB;
    logic [SA-1:0] sIdx;
    logic [LA-1:0] lIdx;
    logic [KA-1:0] byteCnt;
    logic [NW-1:0] mixCnt;
    logic [W-1:0]  initVal;

    logic [LA-1:0] loadIdx;
    logic [W-1:0]  loadWord;
    logic [W-1:0]  mixA;
    logic [W-1:0]  mixB;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [RW-1:0] s);
        return (x << s) | (x >> (W - int'(s)));
    endfunction

    // State register; reset aborts any run in progress without a done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Phase sequencing: each phase ends when its own counter reaches its last value.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (iStart) nextState = LOAD_L;
            LOAD_L:  if (byteCnt == '0) nextState = INIT_S;
            INIT_S:  if (sIdx == SA'(T - 1)) nextState = MIX;
            MIX:     if (mixCnt == NW'(N - 1)) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // One key-schedule step per cycle: byte packing into L, and the full A/B mixing chain.
    always_comb begin
        loadIdx  = LA'(32'(byteCnt) / U);
        loadWord = (lMem[loadIdx] << 8) + W'(keyMem[byteCnt]);
        mixA     = rotl(sTable[sIdx] + accA + accB, RW'(3));
        mixB     = rotl(lMem[lIdx] + mixA + accB, RW'(mixA + accB));
    end

    // Key storage, L/S tables, accumulators and indices, updated per phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int x = 0; x < B; x++) keyMem[x] <= '0;
            for (int x = 0; x < C; x++) lMem[x] <= '0;
            for (int x = 0; x < T; x++) sTable[x] <= '0;
            accA    <= '0;
            accB    <= '0;
            sIdx    <= '0;
            lIdx    <= '0;
            byteCnt <= '0;
            mixCnt  <= '0;
            initVal <= '0;
        end else begin
            if (state == IDLE && iWen && (32'(iKey_address) < 32'(B))) begin
                keyMem[iKey_address] <= iKey_sub_i;
            end
            case (state)
                IDLE: begin
                    if (iStart) begin
                        for (int x = 0; x < C; x++) lMem[x] <= '0;
                        byteCnt <= KA'(B - 1);
                        accA    <= '0;
                        accB    <= '0;
                        sIdx    <= '0;
                        lIdx    <= '0;
                        mixCnt  <= '0;
                        initVal <= PW;
                    end
                end
                LOAD_L: begin
                    lMem[loadIdx] <= loadWord;
                    byteCnt       <= byteCnt - KA'(1);
                end
                INIT_S: begin
                    sTable[sIdx] <= initVal;
                    initVal      <= initVal + QW;
                    sIdx         <= (sIdx == SA'(T - 1)) ? '0 : sIdx + SA'(1);
                end
                MIX: begin
                    sTable[sIdx] <= mixA;
                    lMem[lIdx]   <= mixB;
                    accA         <= mixA;
                    accB         <= mixB;
                    sIdx         <= (sIdx == SA'(T - 1)) ? '0 : sIdx + SA'(1);
                    lIdx         <= (lIdx == LA'(C - 1)) ? '0 : lIdx + LA'(1);
                    mixCnt       <= mixCnt + NW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Registered S read port; addresses past the table read as zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oS <= '0;
        end else begin
            oS <= (32'(iS_address) < 32'(T)) ? sTable[iS_address] : '0;
        end
    end

    assign oBusy = (state == LOAD_L) || (state == INIT_S) || (state == MIX);
    assign oDone = (state == DONE);

endmodule
